// File: rtl/lfsr_stream_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_dec_pkg
// Description : Shared types and constants for the LFSR stream decoder.
//               - dec_state_t : decoder control states
//               - SPACE       : known preamble plaintext character
//               - TAPS        : candidate 7-bit feedback tap patterns
//               - lfsr_step   : one LFSR advance, shared by every lane
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_dec_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRAIN  = 2'd1,
        DECODE = 2'd2,
        DROP   = 2'd3
    } dec_state_t;

    localparam logic [6:0] SPACE = 7'h20;

    localparam logic [6:0] TAPS [0:8] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    // Shift left, feeding back the parity of the tapped bits into bit 0.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s,
                                             input logic [6:0] tap);
        return {s[5:0], ^(s & tap)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_stream_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_stream_decoder_if
// Description : Cipher-in / plaintext-out valid/ready streams.
//               InValid/InReady/InData/InLast   : cipher byte stream
//               OutValid/OutReady/OutData/OutLast : plaintext byte stream
//               slave  modport : the decoder
//               master modport : the producer/consumer around the decoder
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_stream_decoder_if;

    logic       InValid;
    logic       InReady;
    logic [7:0] InData;
    logic       InLast;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] OutData;
    logic       OutLast;

    modport slave (
        input  InValid, InData, InLast, OutReady,
        output InReady, OutValid, OutData, OutLast
    );

    modport master (
        output InValid, InData, InLast, OutReady,
        input  InReady, OutValid, OutData, OutLast
    );

endinterface
`default_nettype wire

// File: rtl/lfsr_stream_decoder_lane.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_lane
// Description : One 7-bit LFSR with a fixed tap pattern.
//               Clk, Reset_n : clock, async active-low reset
//               i_load       : load i_load_val and advance once in one cycle
//               i_load_val   : value loaded (the seed)
//               i_step       : advance the current state
//               o_state      : current LFSR state
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_lane
    import lfsr_dec_pkg::*;
#(
    parameter logic [6:0] TAP = 7'h60
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       i_load,
    input  logic [6:0] i_load_val,
    input  logic       i_step,
    output logic [6:0] o_state
);

    logic [6:0] r_state;

    // Loading also steps: the seed byte has been consumed, so the lane must
    // already hold the key for the following byte.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= '0;
        end else if (i_load) begin
            r_state <= lfsr_step(i_load_val, TAP);
        end else if (i_step) begin
            r_state <= lfsr_step(r_state, TAP);
        end
    end

    assign o_state = r_state;

endmodule
`default_nettype wire

// File: rtl/lfsr_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_stream_decoder
// Description : Recovers the tap pattern and seed of an LFSR-encrypted byte
//               stream from a preamble of spaces, then emits plaintext.
//               Clk     : clock
//               Reset_n : async active-low reset
//               bus     : cipher in / plaintext out streams (slave side)
//               Locked  : a tap has been selected for the current message
//               TapSel  : index of the selected tap (valid while Locked)
//               Error   : sticky, current message failed training / too short
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_stream_decoder
    import lfsr_dec_pkg::*;
#(
    parameter int PRE_CHECK = 6,
    parameter int NUM_TAPS  = 9
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    lfsr_stream_decoder_if.slave  bus,
    output logic                  Locked,
    output logic [3:0]            TapSel,
    output logic                  Error
);

    localparam int                 c_CNT_W   = $clog2(PRE_CHECK + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_PRE_CNT = c_CNT_W'(PRE_CHECK);

    dec_state_t            r_state, w_state_nxt;
    logic [NUM_TAPS-1:0]   r_mask, w_mask_nxt;
    logic [c_CNT_W-1:0]    r_count, w_count_nxt;
    logic                  r_error, w_error_nxt;
    logic                  r_locked, w_locked_nxt;
    logic [3:0]            r_tapsel, w_tapsel_nxt;
    logic                  r_out_valid, w_out_valid_nxt;
    logic [7:0]            r_out_data, w_out_data_nxt;
    logic                  r_out_last, w_out_last_nxt;

    logic [6:0]            w_lane_state [0:NUM_TAPS-1];
    logic [NUM_TAPS-1:0]   w_load, w_step, w_match, w_mask_upd;
    logic [6:0]            w_cipher7, w_keystream, w_sel_lane;
    logic [3:0]            w_lowest;
    logic [c_CNT_W-1:0]    w_cnt_inc;
    logic                  w_in_ready, w_in_fire;
    logic                  w_unused_in_bit7;

    assign w_cipher7        = bus.InData[6:0];
    assign w_unused_in_bit7 = bus.InData[7];
    // During training the expected plaintext is a space, so the keystream
    // byte is directly recoverable from the cipher.
    assign w_keystream      = w_cipher7 ^ SPACE;

    generate
        for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_lane
            lfsr_lane #(
                .TAP (TAPS[gi])
            ) u_lane (
                .Clk        (Clk),
                .Reset_n    (Reset_n),
                .i_load     (w_load[gi]),
                .i_load_val (w_keystream),
                .i_step     (w_step[gi]),
                .o_state    (w_lane_state[gi])
            );
            assign w_match[gi] = (w_lane_state[gi] == w_keystream);
        end
    endgenerate

    assign w_mask_upd = r_mask & w_match;
    assign w_cnt_inc  = r_count + 1'b1;

    // Lowest surviving candidate wins when several taps fit the preamble.
    always_comb begin
        w_lowest = '0;
        for (int i = NUM_TAPS - 1; i >= 0; i--) begin
            if (w_mask_upd[i]) begin
                w_lowest = 4'(i);
            end
        end
    end

    always_comb begin
        w_sel_lane = '0;
        for (int i = 0; i < NUM_TAPS; i++) begin
            if (4'(i) == r_tapsel) begin
                w_sel_lane = w_lane_state[i];
            end
        end
    end

    // Only DECODE produces output, so only DECODE can be back-pressured.
    assign w_in_ready = (r_state == DECODE) ? (!r_out_valid || bus.OutReady) : 1'b1;
    assign w_in_fire  = bus.InValid && w_in_ready;

    always_comb begin
        w_state_nxt     = r_state;
        w_mask_nxt      = r_mask;
        w_count_nxt     = r_count;
        w_error_nxt     = r_error;
        w_locked_nxt    = r_locked;
        w_tapsel_nxt    = r_tapsel;
        w_out_valid_nxt = r_out_valid && !bus.OutReady;
        w_out_data_nxt  = r_out_data;
        w_out_last_nxt  = r_out_last;
        w_load          = '0;
        w_step          = '0;

        case (r_state)
            IDLE: begin
                if (w_in_fire) begin
                    w_load       = '1;
                    w_mask_nxt   = '1;
                    w_count_nxt  = c_CNT_ONE;
                    w_locked_nxt = 1'b0;
                    if (bus.InLast) begin
                        w_error_nxt = 1'b1;
                    end else begin
                        w_error_nxt = 1'b0;
                        w_state_nxt = TRAIN;
                    end
                end
            end

            TRAIN: begin
                if (w_in_fire) begin
                    w_step      = '1;
                    w_mask_nxt  = w_mask_upd;
                    w_count_nxt = w_cnt_inc;
                    if (bus.InLast) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = IDLE;
                    end else if (w_cnt_inc == c_PRE_CNT) begin
                        if (|w_mask_upd) begin
                            w_tapsel_nxt = w_lowest;
                            w_locked_nxt = 1'b1;
                            w_state_nxt  = DECODE;
                        end else begin
                            w_error_nxt = 1'b1;
                            w_state_nxt = DROP;
                        end
                    end
                end
            end

            DECODE: begin
                if (w_in_fire) begin
                    w_out_valid_nxt = 1'b1;
                    w_out_data_nxt  = {1'b0, w_cipher7 ^ w_sel_lane};
                    w_out_last_nxt  = bus.InLast;
                    for (int i = 0; i < NUM_TAPS; i++) begin
                        w_step[i] = (4'(i) == r_tapsel);
                    end
                    if (bus.InLast) begin
                        w_state_nxt = IDLE;
                    end
                end
            end

            DROP: begin
                if (w_in_fire && bus.InLast) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= IDLE;
            r_mask      <= '1;
            r_count     <= '0;
            r_error     <= 1'b0;
            r_locked    <= 1'b0;
            r_tapsel    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mask      <= w_mask_nxt;
            r_count     <= w_count_nxt;
            r_error     <= w_error_nxt;
            r_locked    <= w_locked_nxt;
            r_tapsel    <= w_tapsel_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_last  <= w_out_last_nxt;
        end
    end

    assign bus.InReady  = w_in_ready;
    assign bus.OutValid = r_out_valid;
    assign bus.OutData  = r_out_data;
    assign bus.OutLast  = r_out_last;
    assign Locked       = r_locked;
    assign TapSel       = r_tapsel;
    assign Error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_stream_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_stream_decoder
// Description : Self-checking bench for lfsr_stream_decoder. Messages are
//               planned into queues; a reference model brute-forces every
//               candidate tap against the preamble to predict lock, tap,
//               error and the plaintext stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_stream_decoder;

    localparam int c_P  = 6;
    localparam int c_NT = 9;
    localparam logic [6:0] c_TAB [0:8] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       Locked;
    logic [3:0] TapSel;
    logic       Error;

    always #5 Clk = ~Clk;

    lfsr_stream_decoder_if bus ();

    lfsr_stream_decoder #(
        .PRE_CHECK (c_P),
        .NUM_TAPS  (c_NT)
    ) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus.slave),
        .Locked  (Locked),
        .TapSel  (TapSel),
        .Error   (Error)
    );

    typedef struct { logic [7:0] data; bit last; bit enter_dec; } beat_t;
    typedef struct { logic [7:0] data; bit last; } obyte_t;
    typedef struct { bit locked; logic [3:0] tsel; bit error; } status_t;

    beat_t   in_q  [$];
    obyte_t  exp_q [$];
    status_t st_q  [$];

    int         n_assert   = 0;
    int         n_fail     = 0;
    int         valid_pct  = 100;
    int         ready_pct  = 100;
    int         stall_cnt  = 0;
    bit         stall_arm  = 0;
    bit         in_decode  = 0;
    bit         st_pending = 0;
    bit         held       = 0;
    logic [7:0] held_data;
    logic       held_last;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] ref_step(input logic [6:0] s, input logic [6:0] tap);
        int fb;
        fb = $countones(s & tap) % 2;
        return 7'(((int'(s) * 2) % 128) + fb);
    endfunction

    // Predict the decoder's behaviour for one message of cipher bytes.
    task automatic plan_msg(input logic [7:0] c [$]);
        int         len;
        int         sel;
        bit         ok;
        bit         locked;
        logic [6:0] seed, s;
        status_t    st;
        beat_t      b;
        obyte_t     o;
        len  = c.size();
        seed = c[0][6:0] ^ 7'h20;
        sel  = -1;
        for (int t = c_NT - 1; t >= 0; t--) begin
            s  = seed;
            ok = 1;
            for (int k = 1; k < c_P && k < len; k++) begin
                s = ref_step(s, c_TAB[t]);
                if (s != (c[k][6:0] ^ 7'h20)) ok = 0;
            end
            if (ok) sel = t;
        end
        locked    = (len > c_P) && (sel >= 0);
        st.locked = locked;
        st.tsel   = locked ? 4'(sel) : 4'd0;
        st.error  = !locked;
        st_q.push_back(st);
        for (int k = 0; k < len; k++) begin
            b.data      = c[k];
            b.last      = (k == len - 1);
            b.enter_dec = locked && (k == c_P - 1);
            in_q.push_back(b);
        end
        if (locked) begin
            s = seed;
            for (int k = 1; k < len; k++) begin
                s = ref_step(s, c_TAB[sel]);
                if (k >= c_P) begin
                    o.data = {1'b0, c[k][6:0] ^ s};
                    o.last = (k == len - 1);
                    exp_q.push_back(o);
                end
            end
        end
    endtask

    // Build an encrypted message: kind 0 = good, 1 = corrupted preamble, 2 = short.
    task automatic gen_msg(input int kind);
        logic [7:0] c [$];
        logic [6:0] s, plain;
        int         tap, len, pos;
        s   = 7'($urandom);
        tap = $urandom_range(c_NT - 1);
        len = (kind == 2) ? $urandom_range(c_P, 1) : $urandom_range(c_P + 10, c_P + 1);
        for (int k = 0; k < len; k++) begin
            plain = (k < c_P) ? 7'h20 : 7'($urandom);
            c.push_back({1'($urandom), plain ^ s});
            s = ref_step(s, c_TAB[tap]);
        end
        if (kind == 1) begin
            pos = $urandom_range(c_P - 1, 1);
            c[pos][$urandom_range(6)] ^= 1'b1;
        end
        plan_msg(c);
    endtask

    task automatic cycle();
        beat_t   b;
        obyte_t  e;
        status_t st;
        @(negedge Clk);
        if (stall_arm && bus.OutValid) begin
            stall_cnt = 4;
            stall_arm = 0;
        end
        if (stall_cnt > 0) begin
            bus.OutReady = 1'b0;
            stall_cnt--;
        end else begin
            bus.OutReady = ($urandom_range(99) < ready_pct);
        end
        if (in_q.size() > 0 && $urandom_range(99) < valid_pct) begin
            bus.InValid = 1'b1;
            bus.InData  = in_q[0].data;
            bus.InLast  = in_q[0].last;
        end else begin
            bus.InValid = 1'b0;
            bus.InData  = 8'($urandom);
            bus.InLast  = 1'($urandom);
        end
        #1;
        if (st_pending) begin
            st = st_q.pop_front();
            check("status_locked", Locked, st.locked);
            check("status_error", Error, st.error);
            if (st.locked) check("status_tapsel", TapSel, st.tsel);
            st_pending = 0;
        end
        if (held) begin
            check("hold_valid", bus.OutValid, 1);
            check("hold_data", bus.OutData, held_data);
            check("hold_last", bus.OutLast, held_last);
        end
        if (in_decode)
            check("in_ready_decode", bus.InReady, !(bus.OutValid && !bus.OutReady));
        else
            check("in_ready_other", bus.InReady, 1);
        if (bus.OutValid && bus.OutReady) begin
            check("out_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_data", bus.OutData, e.data);
                check("out_last", bus.OutLast, e.last);
            end
        end
        held      = bus.OutValid && !bus.OutReady;
        held_data = bus.OutData;
        held_last = bus.OutLast;
        if (bus.InValid && bus.InReady) begin
            b = in_q.pop_front();
            if (b.enter_dec) in_decode = 1;
            if (b.last) begin
                in_decode  = 0;
                st_pending = 1;
            end
        end
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0 || st_pending) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", (in_q.size() == 0) && (exp_q.size() == 0) && !st_pending, 1);
        repeat (3) cycle();
    endtask

    task automatic clear_model();
        in_q.delete();
        exp_q.delete();
        st_q.delete();
        in_decode  = 0;
        st_pending = 0;
        held       = 0;
        stall_cnt  = 0;
        stall_arm  = 0;
    endtask

    logic [7:0] m_norm [$] = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'h00};
    logic [7:0] m_bp   [$] = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'h00, 8'h15, 8'h6A, 8'h33};
    logic [7:0] m_bad  [$] = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h31, 8'h00, 8'h05, 8'h0A};
    logic [7:0] m_shrt [$] = '{8'h21, 8'h22, 8'h24};
    logic [7:0] m_long [$];

    initial begin
        int n;
        Reset_n      = 1'b0;
        bus.InValid  = 1'b0;
        bus.InData   = 8'h00;
        bus.InLast   = 1'b0;
        bus.OutReady = 1'b0;
        #2;
        check("rst_out_valid", bus.OutValid, 0);
        check("rst_out_last", bus.OutLast, 0);
        check("rst_out_data", bus.OutData, 0);
        check("rst_locked", Locked, 0);
        check("rst_error", Error, 0);
        check("rst_tapsel", TapSel, 0);
        check("rst_in_ready", bus.InReady, 1);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b1;

        // Normal decode: single plaintext 0x41 after a 6-byte preamble.
        plan_msg(m_norm);
        run_until_idle(200);

        // Backpressure: consumer stalls 4 cycles on the first output.
        stall_arm = 1;
        plan_msg(m_bp);
        run_until_idle(200);

        // Wrong preamble: every candidate ruled out, message dropped.
        plan_msg(m_bad);
        run_until_idle(200);

        // Short message, then a clean one that must clear Error.
        plan_msg(m_shrt);
        plan_msg(m_norm);
        run_until_idle(200);

        // Reset in the middle of DECODE with an output pending.
        m_long = m_norm;
        for (int k = 0; k < 8; k++) m_long.push_back(8'($urandom));
        plan_msg(m_long);
        ready_pct = 0;
        n = 0;
        while (!(in_decode && bus.OutValid) && n < 100) begin
            cycle();
            n++;
        end
        check("reach_decode", in_decode && bus.OutValid, 1);
        @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        check("async_rst_out_valid", bus.OutValid, 0);
        check("async_rst_locked", Locked, 0);
        check("async_rst_error", Error, 0);
        clear_model();
        bus.InValid = 1'b0;
        @(negedge Clk);
        Reset_n   = 1'b1;
        ready_pct = 100;
        plan_msg(m_norm);
        run_until_idle(200);

        // Back-to-back messages, full rate then with random backpressure.
        plan_msg(m_norm);
        gen_msg(0);
        plan_msg(m_bp);
        run_until_idle(300);
        ready_pct = 50;
        gen_msg(0);
        gen_msg(0);
        plan_msg(m_norm);
        run_until_idle(500);

        // Randomized mix of good, corrupted and short messages.
        for (int r = 0; r < 4; r++) begin
            valid_pct = $urandom_range(100, 50);
            ready_pct = $urandom_range(100, 40);
            for (int m = 0; m < 10; m++) begin
                n = $urandom_range(99);
                gen_msg((n < 70) ? 0 : (n < 85) ? 1 : 2);
            end
            run_until_idle(4000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/lfsr_stream_decoder.md
Name: lfsr_stream_decoder

Overview:
- Receiver-side counterpart of the processor's LFSR encryption path: consumes a stream of encrypted bytes and recovers the unknown tap pattern and seed from a known space (0x20) preamble.
- Emits decrypted plaintext bytes over a valid/ready stream.
- Sits between the data-memory byte streamer and the result buffer as a hardware checker/decrypter for the encryption program's output.

Parameters:
- PRE_CHECK, 6, number of leading cipher bytes used for training; all are required to be encrypted spaces (minimum 2).
- NUM_TAPS, 9, number of candidate tap patterns held in the package table.

Ports:
- Clk  in  1  clock; all state updates on posedge.
- Reset_n  in  1  asynchronous, active-low reset.
- InValid  in  1  cipher byte valid.
- InReady  out  1  decoder accepts cipher byte.
- InData  in  8  cipher byte; bit 7 ignored.
- InLast  in  1  marks final byte of message; qualified by InValid.
- OutValid  out  1  plaintext byte valid.
- OutReady  in  1  downstream accepts plaintext.
- OutData  out  8  plaintext byte; bit 7 always 0.
- OutLast  out  1  marks final plaintext byte.
- Locked  out  1  a single tap pattern has been selected for the current message.
- TapSel  out  4  index of the selected tap; valid while Locked.
- Error  out  1  sticky: current message failed training or was too short.

Behaviour:
- Transfer: a byte moves when Valid and Ready are both high on a posedge.
- LFSR step: next = {s[5:0], ^(s & tap)}.
- Cipher model: byte k is {1'b0, plain_k[6:0] ^ state_k}, with state_{k+1} = step(state_k).
- Reset: state IDLE; OutValid, OutLast, Locked, Error = 0; OutData = 0; TapSel = 0; all lane states = 0; byte count = 0; candidate mask = all ones.
- IDLE:
  - InReady = 1.
  - On first accept: every lane loads InData[6:0] ^ 7'h20, then steps.
  - Mask = all ones, count = 1, Error and Locked cleared.
  - Go to TRAIN. If InLast is also set: Error = 1, stay in IDLE.
- TRAIN:
  - InReady = 1.
  - Each accept clears mask bit i when lane_i state != InData[6:0] ^ 7'h20. All lanes then step and count increments.
  - When count reaches PRE_CHECK after this accept:
    - Mask nonzero: TapSel = lowest set index, Locked = 1, go to DECODE.
    - Mask zero: Error = 1, go to DROP.
  - InLast in TRAIN: Error = 1 and go to IDLE, regardless of the mask.
- DECODE:
  - InReady = !OutValid || OutReady (single-entry output register).
  - On accept, on the next cycle: OutData = {1'b0, InData[6:0] ^ lane[TapSel]}, OutValid = 1, OutLast = InLast. The selected lane steps.
  - Latency is 1 cycle from accept to OutValid.
  - Accepting InLast moves to IDLE after the output register loads. Locked stays 1 until the next message's first byte.
- DROP: InReady = 1; bytes are discarded with no output. InLast returns to IDLE. Error stays 1.
- OutValid holds, with OutData stable, until OutReady. Back-to-back throughput is 1 byte per cycle while OutReady = 1.
- The output register drains normally after returning to IDLE. A new message may start while the last output is pending.
- Preamble bytes are never emitted; output begins with byte index PRE_CHECK.
- Reset_n asserted mid-message: immediate return to reset values; partial output is lost.

Decomposition:
- Package lfsr_dec_pkg:
  - state enum {IDLE, TRAIN, DECODE, DROP};
  - SPACE = 7'h20;
  - tap table TAPS[9] = {7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B}.
- Sub-module lfsr_lane: one 7-bit LFSR with load, step and tap input, instantiated NUM_TAPS times via generate.

Test Plan:
- Normal decode, tap 0x60, seed 0x01. Cipher 21 22 24 28 30 00, then 00 with InLast -> after 6 bytes Locked = 1, TapSel = 0; one output 0x41 with OutLast = 1; Error = 0.
- Backpressure: same stream plus 3 more bytes, OutReady held 0 for 4 cycles after the first output -> InReady = 0 while OutValid is pending; OutData stable; no byte lost or duplicated.
- Wrong preamble: cipher 21 22 24 28 31 ... InLast -> mask reaches zero at byte 5; Error = 1; no OutValid; state DROP, then IDLE on InLast.
- Short message: 3 bytes with InLast on the third -> Error = 1, Locked = 0, back in IDLE; the next message then trains cleanly and clears Error.
- Reset_n pulsed low in DECODE -> OutValid = 0, Locked = 0, Error = 0 within the same cycle (async); the next byte is treated as a preamble start.
- Back-to-back messages: second message's first byte presented the cycle after the first message's InLast -> accepted; the first message's last output still delivered correctly.
